// File: rtl/err_inject_seq.sv
// err_inject_seq -- error-injection sequencer for a downstream splitter tree.
//
// A configuration (mask, delay, duration, mode) is accepted while idle.
// The sequencer waits 'delay' cycles, then drives err_en high with
// err_ctrl = mask for max(dur,1) cycles. After the window it either
// finishes (one-shot, and the reserved mode 3), re-arms (periodic) or holds
// the window forever (sticky). abort ends any active sequence with a
// one-cycle done pulse. rst returns to idle without a done pulse.
//
// Optional feature: define ERR_INJ_COUNT_EN to count injection windows on
// inj_count. The count saturates and clears on reset and on each accepted
// configuration. Without the macro inj_count is tied to zero.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   cfg_valid/ready configuration handshake (ready only while idle)
//   cfg_mask        sites to corrupt (CTRLW bits)
//   cfg_delay       wait before each window (CNTW bits)
//   cfg_dur         window length, 0 behaves as 1 (CNTW bits)
//   cfg_mode        0 one-shot, 1 periodic, 2 sticky, 3 as one-shot
//   abort           terminate active sequence (ignored while idle)
//   err_en/err_ctrl registered injection enable / site controls
//   busy            sequencer not idle
//   done            single-cycle completion/abort pulse
//   inj_count       injection windows entered
module err_inject_seq #(
   parameter int CTRLW = 4,
   parameter int CNTW  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CTRLW-1:0] cfg_mask,
   input  logic [CNTW-1:0]  cfg_delay,
   input  logic [CNTW-1:0]  cfg_dur,
   input  logic [1:0]       cfg_mode,
   input  logic             abort,
   output logic             err_en,
   output logic [CTRLW-1:0] err_ctrl,
   output logic             busy,
   output logic             done,
   output logic [CNTW-1:0]  inj_count
);

   typedef enum logic [1:0] {IDLE, ARMED, INJECT} state_t;

   state_t           state, state_nx;
   logic [CTRLW-1:0] mask_q, mask_nx;
   logic [CNTW-1:0]  delay_q, delay_nx;
   logic [CNTW-1:0]  dur_q, dur_nx;
   logic [1:0]       mode_q, mode_nx;
   logic [CNTW-1:0]  cnt_q, cnt_nx;   // shared delay / duration counter
   logic             err_en_nx, done_nx;
   logic [CTRLW-1:0] err_ctrl_nx;
   logic [CNTW-1:0]  dur_m1;

   // Window length minus one, with dur=0 treated as a one-cycle window.
   assign dur_m1    = (dur_q == '0) ? '0 : dur_q - 1'b1;
   assign cfg_ready = (state == IDLE);
   assign busy      = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         mask_q   <= '0;
         delay_q  <= '0;
         dur_q    <= '0;
         mode_q   <= '0;
         cnt_q    <= '0;
         err_en   <= 1'b0;
         err_ctrl <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_nx;
         mask_q   <= mask_nx;
         delay_q  <= delay_nx;
         dur_q    <= dur_nx;
         mode_q   <= mode_nx;
         cnt_q    <= cnt_nx;
         err_en   <= err_en_nx;
         err_ctrl <= err_ctrl_nx;
         done     <= done_nx;
      end
   end

   // Outputs are computed for the next state so they appear registered in
   // the same cycle the state takes effect.
   always_comb begin
      state_nx    = state;
      mask_nx     = mask_q;
      delay_nx    = delay_q;
      dur_nx      = dur_q;
      mode_nx     = mode_q;
      cnt_nx      = cnt_q;
      err_en_nx   = 1'b0;
      err_ctrl_nx = '0;
      done_nx     = 1'b0;
      case (state)
         IDLE: begin
            // abort is ignored here, even together with cfg_valid
            if (cfg_valid) begin
               mask_nx  = cfg_mask;
               delay_nx = cfg_delay;
               dur_nx   = cfg_dur;
               mode_nx  = cfg_mode;
               cnt_nx   = cfg_delay;
               state_nx = ARMED;
            end
         end
         ARMED: begin
            if (abort) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else if (cnt_q == '0) begin
               state_nx    = INJECT;
               cnt_nx      = dur_m1;
               err_en_nx   = 1'b1;
               err_ctrl_nx = mask_q;
            end else begin
               cnt_nx = cnt_q - 1'b1;
            end
         end
         INJECT: begin
            if (abort) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end else if (mode_q == 2'd2) begin
               err_en_nx   = 1'b1;
               err_ctrl_nx = mask_q;
            end else if (cnt_q == '0) begin
               if (mode_q == 2'd1) begin
                  state_nx = ARMED;
                  cnt_nx   = delay_q;
               end else begin
                  state_nx = IDLE;
                  done_nx  = 1'b1;
               end
            end else begin
               cnt_nx      = cnt_q - 1'b1;
               err_en_nx   = 1'b1;
               err_ctrl_nx = mask_q;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

`ifdef ERR_INJ_COUNT_EN
   logic            inj_entry, cfg_accept;
   logic [CNTW-1:0] inj_cnt_q;

   assign cfg_accept = (state == IDLE) && cfg_valid;
   assign inj_entry  = (state == ARMED) && !abort && (cnt_q == '0);

   always_ff @(posedge clk) begin
      if (rst || cfg_accept)
         inj_cnt_q <= '0;
      else if (inj_entry && (inj_cnt_q != '1))
         inj_cnt_q <= inj_cnt_q + 1'b1;
   end

   assign inj_count = inj_cnt_q;
`else
   assign inj_count = '0;
`endif

endmodule
